// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: condition encoding
// and the hard-wired zero register number.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHaz   = 2'd1,
        StMem   = 2'd2,
        StFlush = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_raw_detect.sv
// Combinational RAW check of one in-flight writer against the ID-stage sources.
module raw_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       wr_en,
    input  logic [4:0] dest,
    input  logic [4:0] src1,
    input  logic [4:0] src2,
    input  logic       two_src,
    output logic       hit
);

    // Writes to the zero register are discarded, so they never create a dependency.
    assign hit = wr_en && (dest != REG_ZERO) &&
                 ((dest == src1) || (two_src && (dest == src2)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller. Define FORWARDING_EN to restrict hazard
// detection to load-use on the EXE writer (forwarding covers the rest).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             src1_id,
    input  logic [4:0]             src2_id,
    input  logic                   two_src_id,
    input  logic                   wb_en_exe,
    input  logic                   mem_r_en_exe,
    input  logic [4:0]             dest_exe,
    input  logic                   wb_en_mem,
    input  logic [4:0]             dest_mem,
    input  logic                   br_taken_exe,
    input  logic                   mem_busy,
    input  logic                   clr_cnt,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_exe_en,
    output logic                   exe_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_exe_bubble,
    output logic                   freeze,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_e                 state_q, state_d;
    logic                   br_pend_q, br_pend_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hit_exe;
    logic                   hazard;

    raw_detect u_raw_exe (
        .wr_en   (wb_en_exe),
        .dest    (dest_exe),
        .src1    (src1_id),
        .src2    (src2_id),
        .two_src (two_src_id),
        .hit     (hit_exe)
    );

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time.
    logic unused_mem_writer;
    assign unused_mem_writer = wb_en_mem ^ (^dest_mem);
    assign hazard = mem_r_en_exe && hit_exe;
`else
    logic hit_mem;
    logic unused_load_flag;

    raw_detect u_raw_mem (
        .wr_en   (wb_en_mem),
        .dest    (dest_mem),
        .src1    (src1_id),
        .src2    (src2_id),
        .two_src (two_src_id),
        .hit     (hit_mem)
    );

    assign unused_load_flag = mem_r_en_exe;
    assign hazard = hit_exe || hit_mem;
`endif

    always_comb begin
        state_d       = StRun;
        br_pend_d     = br_pend_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_exe_en     = 1'b1;
        exe_mem_en    = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        freeze        = hazard;

        if (mem_busy) begin
            // Whole pipe holds; a branch resolved now must survive the hold.
            state_d    = StMem;
            br_pend_d  = br_pend_q || br_taken_exe;
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_exe_en  = 1'b0;
            exe_mem_en = 1'b0;
            mem_wb_en  = 1'b0;
        end else if (br_taken_exe || br_pend_q) begin
            state_d       = StFlush;
            br_pend_d     = 1'b0;
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
        end else if (hazard) begin
            state_d       = StHaz;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_bubble = 1'b1;
        end

        if (!rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_en    = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b0;
            id_exe_bubble = 1'b0;
            freeze        = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (!pc_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            br_pend_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            br_pend_q <= br_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model predicts each cycle's outputs,
// which are queued at drive time and compared when the DUT outputs settle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  src1_id = '0, src2_id = '0, dest_exe = '0, dest_mem = '0;
    logic        two_src_id = 0, wb_en_exe = 0, mem_r_en_exe = 0, wb_en_mem = 0;
    logic        br_taken_exe = 0, mem_busy = 0, clr_cnt = 0;
    logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic        if_id_flush, id_exe_bubble, freeze;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .src1_id       (src1_id),
        .src2_id       (src2_id),
        .two_src_id    (two_src_id),
        .wb_en_exe     (wb_en_exe),
        .mem_r_en_exe  (mem_r_en_exe),
        .dest_exe      (dest_exe),
        .wb_en_mem     (wb_en_mem),
        .dest_mem      (dest_mem),
        .br_taken_exe  (br_taken_exe),
        .mem_busy      (mem_busy),
        .clr_cnt       (clr_cnt),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_exe_en     (id_exe_en),
        .exe_mem_en    (exe_mem_en),
        .mem_wb_en     (mem_wb_en),
        .if_id_flush   (if_id_flush),
        .id_exe_bubble (id_exe_bubble),
        .freeze        (freeze),
        .state         (state),
        .stall_cnt     (stall_cnt)
    );

    typedef struct packed {
        logic [4:0]  en;      // {pc, if_id, id_exe, exe_mem, mem_wb}
        logic        flush;
        logic        bubble;
        logic        freeze;
        logic [1:0]  state;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [1:0]  m_state = 2'd0;
    logic        m_pend  = 1'b0;
    logic [15:0] m_cnt   = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic raw(input logic v, input logic [4:0] d);
        return v && (d != 5'd0) && ((d == src1_id) || (two_src_id && (d == src2_id)));
    endfunction

    task automatic predict(output exp_t e, output logic [1:0] cond);
        logic haz;
`ifdef FORWARDING_EN
        haz = mem_r_en_exe && raw(wb_en_exe, dest_exe);
`else
        haz = raw(wb_en_exe, dest_exe) || raw(wb_en_mem, dest_mem);
`endif
        e.state = m_state;
        e.cnt   = m_cnt;
        if (mem_busy) begin
            cond = 2'd2; e.en = 5'b00000; e.flush = 0; e.bubble = 0;
        end else if (br_taken_exe || m_pend) begin
            cond = 2'd3; e.en = 5'b11111; e.flush = 1; e.bubble = 1;
        end else if (haz) begin
            cond = 2'd1; e.en = 5'b00111; e.flush = 0; e.bubble = 1;
        end else begin
            cond = 2'd0; e.en = 5'b11111; e.flush = 0; e.bubble = 0;
        end
        e.freeze = haz;
        if (!rst) begin
            e.en = '0; e.flush = 0; e.bubble = 0; e.freeze = 0;
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        check_eq({tag, ".en"}, 32'({pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en}),
                 32'(e.en));
        check_eq({tag, ".flush"}, 32'(if_id_flush), 32'(e.flush));
        check_eq({tag, ".bubble"}, 32'(id_exe_bubble), 32'(e.bubble));
        check_eq({tag, ".freeze"}, 32'(freeze), 32'(e.freeze));
        check_eq({tag, ".state"}, 32'(state), 32'(e.state));
        check_eq({tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
    endtask

    // Called just after a rising edge with inputs already driven; ends just after the next one.
    task automatic cycle(input string tag, input bit do_chk);
        exp_t       e, g;
        logic [1:0] c;
        predict(e, c);
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        if (do_chk) compare(tag, g);
        @(posedge clk);
        if (rst) begin
            if (c == 2'd2) m_pend = m_pend || br_taken_exe;
            if (c == 2'd3) m_pend = 1'b0;
            if (clr_cnt) m_cnt = 16'd0;
            else if (!e.en[4] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_state = c;
        end
        #1;
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_pend = 1'b0; m_cnt = 16'd0;
    endtask

    task automatic quiet();
        src1_id = 0; src2_id = 0; dest_exe = 0; dest_mem = 0; two_src_id = 0;
        wb_en_exe = 0; mem_r_en_exe = 0; wb_en_mem = 0;
        br_taken_exe = 0; mem_busy = 0; clr_cnt = 0;
    endtask

    initial begin
        exp_t       e, g;
        logic [1:0] c;

        quiet();
        #2;
        model_reset();
        predict(e, c); sb.push_back(e); g = sb.pop_front(); compare("reset", g);
        @(posedge clk); #1;
        rst = 1'b1;

        // Writes to r0 never stall
        dest_exe = 0; wb_en_exe = 1; src1_id = 0;
        cycle("r0_write", 1);

        // MEM-stage writer RAW on src1
        quiet(); src1_id = 5; wb_en_mem = 1; dest_mem = 5;
        cycle("mem_raw", 1);
        quiet();
        cycle("mem_raw_after", 1);

        // EXE-stage writer on src2, only when src2 is actually read
        dest_exe = 7; wb_en_exe = 1; src2_id = 7; two_src_id = 1; mem_r_en_exe = 1;
        cycle("exe_src2", 1);
        two_src_id = 0;
        cycle("exe_src2_imm", 1);

`ifdef FORWARDING_EN
        quiet(); dest_exe = 3; wb_en_exe = 1; src2_id = 3; two_src_id = 1;
        cycle("fwd_alu", 1);
        mem_r_en_exe = 1;
        cycle("fwd_load", 1);
`endif

        // Branch taken while MEM holds, then a single flush cycle
        quiet(); clr_cnt = 1;
        cycle("clr", 1);
        clr_cnt = 0; mem_busy = 1; br_taken_exe = 1;
        src1_id = 9; wb_en_exe = 1; dest_exe = 9;
        for (int i = 0; i < 3; i++) cycle("br_mem", 1);
        quiet();
        cycle("br_flush", 1);
        cycle("br_run", 1);
        cycle("br_run2", 1);

        // Flush outranks a hazard in the same cycle
        src1_id = 4; wb_en_mem = 1; dest_mem = 4; br_taken_exe = 1;
        cycle("flush_vs_haz", 1);
        br_taken_exe = 0; mem_busy = 1;
        cycle("mem_vs_haz", 1);

        // Reset while a branch is pending
        quiet(); mem_busy = 1; br_taken_exe = 1;
        cycle("pend_set", 1);
        br_taken_exe = 0;
        cycle("pend_hold", 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        predict(e, c); sb.push_back(e); g = sb.pop_front(); compare("rst_mid", g);
        mem_busy = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        cycle("post_rst", 1);
        cycle("post_rst2", 1);

        // Stall counter saturation and clear
        src1_id = 6; wb_en_exe = 1; dest_exe = 6;
        for (int i = 0; i < 65541; i++) cycle("sat_run", 0);
        cycle("sat", 1);
        clr_cnt = 1;
        cycle("sat_clr", 1);
        clr_cnt = 0;
        cycle("after_clr", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
